// File: rtl/mem_stage.sv
// Y86-64 memory stage: M pipeline register, data-memory req/ack sequencer
// with timeout, and W pipeline register. Drives m_/M_ forwarding signals.
module mem_stage #(
    parameter logic [63:0] ADDR_LIMIT = 64'h0000_0000_0001_0000,
    parameter int          MAX_WAIT   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        M_stall,
    input  logic        M_bubble,
    input  logic        W_stall,
    input  logic [2:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] E_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  E_dstM,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    input  logic        dmem_err,
    output logic        mem_busy,
    output logic [2:0]  m_stat,
    output logic [63:0] m_valM,
    output logic [63:0] M_valE,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic        M_Cnd,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t         state;
    state_t         state_next;

    logic [2:0]     mreg_stat;
    logic [3:0]     mreg_icode;
    logic [63:0]    mreg_vala;

    logic [CW-1:0]  wait_cnt;
    logic [63:0]    rdata_q;
    logic           err_q;
    logic           served;

    logic           is_read;
    logic           is_write;
    logic [63:0]    mem_addr;
    logic           addr_ok;
    logic           access_req;
    logic           start;
    logic           addr_fault;
    logic           timeout;
    logic           m_hold;

    // ---------------------------------------------------------------
    // M pipeline register
    // ---------------------------------------------------------------
    assign m_hold = M_stall || mem_busy;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mreg_stat  <= STAT_BUB;
            mreg_icode <= I_NOP;
            M_Cnd      <= 1'b0;
            M_valE     <= '0;
            mreg_vala  <= '0;
            M_dstE     <= RNONE;
            M_dstM     <= RNONE;
        end else if (!m_hold) begin
            if (M_bubble) begin
                mreg_stat  <= STAT_BUB;
                mreg_icode <= I_NOP;
                M_Cnd      <= 1'b0;
                M_valE     <= '0;
                mreg_vala  <= '0;
                M_dstE     <= RNONE;
                M_dstM     <= RNONE;
            end else begin
                mreg_stat  <= E_stat;
                mreg_icode <= E_icode;
                M_Cnd      <= e_Cnd;
                M_valE     <= e_valE;
                mreg_vala  <= E_valA;
                M_dstE     <= (E_icode == I_CMOV && !e_Cnd) ? RNONE : e_dstE;
                M_dstM     <= E_dstM;
            end
        end
    end

    // ---------------------------------------------------------------
    // Access classification
    // ---------------------------------------------------------------
    assign is_read    = (mreg_icode == I_MRMOVQ) || (mreg_icode == I_POPQ) ||
                        (mreg_icode == I_RET);
    assign is_write   = (mreg_icode == I_RMMOVQ) || (mreg_icode == I_PUSHQ) ||
                        (mreg_icode == I_CALL);
    assign mem_addr   = (mreg_icode == I_POPQ || mreg_icode == I_RET) ? mreg_vala : M_valE;
    assign addr_ok    = mem_addr < ADDR_LIMIT;
    assign access_req = (is_read || is_write) && (mreg_stat == STAT_AOK);

    // The arrival cycle in IDLE already issues the request, so a same-cycle
    // ack gives exactly one busy cycle. served blocks a repeat access when W
    // has taken the result but M is still stalled on the same instruction.
    assign start      = (state == S_IDLE) && access_req && addr_ok && !served;
    assign addr_fault = (state == S_IDLE) && access_req && !addr_ok;
    assign timeout    = wait_cnt >= CW'(MAX_WAIT - 1);

    // ---------------------------------------------------------------
    // Access FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        mem_busy   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    dmem_req   = 1'b1;
                    mem_busy   = 1'b1;
                    state_next = dmem_ack ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                dmem_req = 1'b1;
                mem_busy = 1'b1;
                if (dmem_ack || timeout) state_next = S_DONE;
            end
            S_DONE: begin
                if (!W_stall) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign dmem_addr  = mem_addr;
    assign dmem_wdata = mreg_vala;
    assign dmem_we    = dmem_req && is_write;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (start) wait_cnt <= CW'(1);
            else if (state == S_ACCESS) wait_cnt <= wait_cnt + CW'(1);

            if (dmem_req && dmem_ack) begin
                rdata_q <= is_read ? dmem_rdata : '0;
                err_q   <= dmem_err;
            end else if (state == S_ACCESS && timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                             served <= 1'b0;
        else if (!m_hold)                       served <= 1'b0;
        else if (state == S_DONE && !W_stall)   served <= 1'b1;
    end

    always_comb begin
        m_stat = mreg_stat;
        if (state == S_DONE && err_q) m_stat = STAT_ADR;
        else if (addr_fault)          m_stat = STAT_ADR;
    end

    assign m_valM = (state == S_DONE && is_read) ? rdata_q : '0;

    // ---------------------------------------------------------------
    // W pipeline register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            W_stat  <= STAT_BUB;
            W_icode <= I_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (!W_stall) begin
            if (mem_busy) begin
                W_stat  <= STAT_BUB;
                W_icode <= I_NOP;
                W_valE  <= '0;
                W_valM  <= '0;
                W_dstE  <= RNONE;
                W_dstM  <= RNONE;
            end else begin
                W_stat  <= m_stat;
                W_icode <= mreg_icode;
                W_valE  <= M_valE;
                W_valM  <= m_valM;
                W_dstE  <= M_dstE;
                W_dstM  <= M_dstM;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one task per scenario, inline comparisons
// against hand-computed values.
module tb_mem_stage;

    logic        clock;
    logic        reset;
    logic        M_stall, M_bubble, W_stall;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic        e_Cnd;
    logic [63:0] e_valE, E_valA;
    logic [3:0]  e_dstE, E_dstM;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_req, dmem_we, dmem_ack, dmem_err;
    logic        mem_busy;
    logic [2:0]  m_stat;
    logic [63:0] m_valM, M_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic        M_Cnd;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;

    int n_checks;
    int n_errors;

    mem_stage dut (
        .clock(clock), .reset(reset),
        .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall),
        .E_stat(E_stat), .E_icode(E_icode), .e_Cnd(e_Cnd),
        .e_valE(e_valE), .E_valA(E_valA), .e_dstE(e_dstE), .E_dstM(E_dstM),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .mem_busy(mem_busy), .m_stat(m_stat), .m_valM(m_valM),
        .M_valE(M_valE), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_Cnd(M_Cnd),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_e(input logic [2:0] stat, input logic [3:0] icode, input logic cnd,
                         input logic [63:0] vale, input logic [63:0] vala,
                         input logic [3:0] dste, input logic [3:0] dstm);
        E_stat  = stat;
        E_icode = icode;
        e_Cnd   = cnd;
        e_valE  = vale;
        E_valA  = vala;
        e_dstE  = dste;
        E_dstM  = dstm;
    endtask

    task automatic set_nop();
        set_e(3'd0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        M_stall = 1'b0; M_bubble = 1'b0; W_stall = 1'b0;
        dmem_rdata = '0; dmem_ack = 1'b0; dmem_err = 1'b0;
        set_nop();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        n_checks++; if (W_stat !== 3'd0) begin n_errors++; $display("FAIL reset_w_stat: got %0h expected 0", W_stat); end
        n_checks++; if (W_icode !== 4'h1) begin n_errors++; $display("FAIL reset_w_icode: got %0h expected 1", W_icode); end
        n_checks++; if (W_dstE !== 4'hF) begin n_errors++; $display("FAIL reset_w_dste: got %0h expected f", W_dstE); end
        n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %0b expected 0", dmem_req); end
        n_checks++; if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", mem_busy); end
        n_checks++; if (m_valM !== 64'h0) begin n_errors++; $display("FAIL reset_m_valm: got %0h expected 0", m_valM); end
    endtask

    task automatic test_mrmovq_latency();
        set_e(3'd1, 4'h5, 1'b0, 64'h100, 64'h0, 4'hF, 4'h3);
        tick();
        set_nop();
        n_checks++; if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL mrm_req: got %0b expected 1", dmem_req); end
        n_checks++; if (dmem_addr !== 64'h100) begin n_errors++; $display("FAIL mrm_addr: got %0h expected 100", dmem_addr); end
        n_checks++; if (dmem_we !== 1'b0) begin n_errors++; $display("FAIL mrm_we: got %0b expected 0", dmem_we); end
        n_checks++; if (mem_busy !== 1'b1) begin n_errors++; $display("FAIL mrm_busy1: got %0b expected 1", mem_busy); end
        tick();
        n_checks++; if (mem_busy !== 1'b1) begin n_errors++; $display("FAIL mrm_busy2: got %0b expected 1", mem_busy); end
        n_checks++; if (W_stat !== 3'd0) begin n_errors++; $display("FAIL mrm_w_bubble1: got %0h expected 0", W_stat); end
        tick();
        dmem_ack = 1'b1; dmem_rdata = 64'hDEAD;
        n_checks++; if (mem_busy !== 1'b1) begin n_errors++; $display("FAIL mrm_busy3: got %0b expected 1", mem_busy); end
        n_checks++; if (dmem_addr !== 64'h100) begin n_errors++; $display("FAIL mrm_addr_hold: got %0h expected 100", dmem_addr); end
        n_checks++; if (W_stat !== 3'd0) begin n_errors++; $display("FAIL mrm_w_bubble2: got %0h expected 0", W_stat); end
        tick();
        dmem_ack = 1'b0; dmem_rdata = 64'h0;
        n_checks++; if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL mrm_done_busy: got %0b expected 0", mem_busy); end
        n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL mrm_done_req: got %0b expected 0", dmem_req); end
        n_checks++; if (m_valM !== 64'hDEAD) begin n_errors++; $display("FAIL mrm_m_valm: got %0h expected dead", m_valM); end
        n_checks++; if (m_stat !== 3'd1) begin n_errors++; $display("FAIL mrm_m_stat: got %0h expected 1", m_stat); end
        tick();
        n_checks++; if (W_valM !== 64'hDEAD) begin n_errors++; $display("FAIL mrm_w_valm: got %0h expected dead", W_valM); end
        n_checks++; if (W_stat !== 3'd1) begin n_errors++; $display("FAIL mrm_w_stat: got %0h expected 1", W_stat); end
        n_checks++; if (W_icode !== 4'h5) begin n_errors++; $display("FAIL mrm_w_icode: got %0h expected 5", W_icode); end
        n_checks++; if (W_dstM !== 4'h3) begin n_errors++; $display("FAIL mrm_w_dstm: got %0h expected 3", W_dstM); end
    endtask

    task automatic test_pushq_single_cycle();
        set_e(3'd1, 4'hA, 1'b0, 64'h1F8, 64'h55, 4'h4, 4'hF);
        tick();
        set_nop();
        dmem_ack = 1'b1;
        n_checks++; if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL push_req: got %0b expected 1", dmem_req); end
        n_checks++; if (dmem_we !== 1'b1) begin n_errors++; $display("FAIL push_we: got %0b expected 1", dmem_we); end
        n_checks++; if (dmem_wdata !== 64'h55) begin n_errors++; $display("FAIL push_wdata: got %0h expected 55", dmem_wdata); end
        n_checks++; if (dmem_addr !== 64'h1F8) begin n_errors++; $display("FAIL push_addr: got %0h expected 1f8", dmem_addr); end
        tick();
        dmem_ack = 1'b0;
        n_checks++; if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL push_busy_one: got %0b expected 0", mem_busy); end
        n_checks++; if (m_stat !== 3'd1) begin n_errors++; $display("FAIL push_m_stat: got %0h expected 1", m_stat); end
        tick();
        n_checks++; if (W_stat !== 3'd1) begin n_errors++; $display("FAIL push_w_stat: got %0h expected 1", W_stat); end
        n_checks++; if (W_valE !== 64'h1F8) begin n_errors++; $display("FAIL push_w_vale: got %0h expected 1f8", W_valE); end
        n_checks++; if (W_valM !== 64'h0) begin n_errors++; $display("FAIL push_w_valm: got %0h expected 0", W_valM); end
    endtask

    task automatic test_addr_limit();
        set_e(3'd1, 4'h4, 1'b0, 64'h10000, 64'h7, 4'hF, 4'hF);
        tick();
        set_nop();
        n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL adr_req: got %0b expected 0", dmem_req); end
        n_checks++; if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL adr_busy: got %0b expected 0", mem_busy); end
        n_checks++; if (m_stat !== 3'd3) begin n_errors++; $display("FAIL adr_m_stat: got %0h expected 3", m_stat); end
        tick();
        n_checks++; if (W_stat !== 3'd3) begin n_errors++; $display("FAIL adr_w_stat: got %0h expected 3", W_stat); end
        n_checks++; if (W_icode !== 4'h4) begin n_errors++; $display("FAIL adr_w_icode: got %0h expected 4", W_icode); end
        // Last valid address must still issue a request.
        set_e(3'd1, 4'h4, 1'b0, 64'hFFFF, 64'h3, 4'hF, 4'hF);
        tick();
        set_nop();
        dmem_ack = 1'b1;
        n_checks++; if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL adr_edge_req: got %0b expected 1", dmem_req); end
        n_checks++; if (m_stat !== 3'd1) begin n_errors++; $display("FAIL adr_edge_stat: got %0h expected 1", m_stat); end
        tick();
        dmem_ack = 1'b0;
        tick();
        n_checks++; if (W_stat !== 3'd1) begin n_errors++; $display("FAIL adr_edge_w_stat: got %0h expected 1", W_stat); end
    endtask

    task automatic test_timeout();
        int n;
        set_e(3'd1, 4'hB, 1'b0, 64'h48, 64'h40, 4'h4, 4'h2);
        tick();
        set_nop();
        n_checks++; if (dmem_addr !== 64'h40) begin n_errors++; $display("FAIL to_addr: got %0h expected 40", dmem_addr); end
        n_checks++; if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL to_req: got %0b expected 1", dmem_req); end
        n = 0;
        while (mem_busy && n < 40) begin
            n++;
            tick();
        end
        n_checks++; if (n !== 16) begin n_errors++; $display("FAIL to_busy_cycles: got %0d expected 16", n); end
        n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL to_req_drop: got %0b expected 0", dmem_req); end
        n_checks++; if (m_stat !== 3'd3) begin n_errors++; $display("FAIL to_m_stat: got %0h expected 3", m_stat); end
        tick();
        n_checks++; if (W_stat !== 3'd3) begin n_errors++; $display("FAIL to_w_stat: got %0h expected 3", W_stat); end
        n_checks++; if (W_dstM !== 4'h2) begin n_errors++; $display("FAIL to_w_dstm: got %0h expected 2", W_dstM); end
    endtask

    task automatic test_cmov();
        set_e(3'd1, 4'h2, 1'b0, 64'h9, 64'h0, 4'h2, 4'hF);
        tick();
        n_checks++; if (M_dstE !== 4'hF) begin n_errors++; $display("FAIL cmov_nt_dste: got %0h expected f", M_dstE); end
        n_checks++; if (M_Cnd !== 1'b0) begin n_errors++; $display("FAIL cmov_nt_cnd: got %0b expected 0", M_Cnd); end
        n_checks++; if (M_valE !== 64'h9) begin n_errors++; $display("FAIL cmov_nt_vale: got %0h expected 9", M_valE); end
        set_e(3'd1, 4'h2, 1'b1, 64'h9, 64'h0, 4'h2, 4'hF);
        tick();
        n_checks++; if (M_dstE !== 4'h2) begin n_errors++; $display("FAIL cmov_t_dste: got %0h expected 2", M_dstE); end
        n_checks++; if (M_Cnd !== 1'b1) begin n_errors++; $display("FAIL cmov_t_cnd: got %0b expected 1", M_Cnd); end
        set_nop();
        tick();
    endtask

    task automatic test_bubble_and_nonaok();
        set_e(3'd1, 4'h6, 1'b1, 64'h11, 64'h0, 4'h3, 4'hF);
        M_bubble = 1'b1;
        tick();
        n_checks++; if (M_dstE !== 4'hF) begin n_errors++; $display("FAIL bub_dste: got %0h expected f", M_dstE); end
        n_checks++; if (M_valE !== 64'h0) begin n_errors++; $display("FAIL bub_vale: got %0h expected 0", M_valE); end
        M_bubble = 1'b0;
        tick();
        n_checks++; if (M_valE !== 64'h11) begin n_errors++; $display("FAIL bub_load: got %0h expected 11", M_valE); end
        M_bubble = 1'b1; M_stall = 1'b1;
        tick();
        n_checks++; if (M_valE !== 64'h11) begin n_errors++; $display("FAIL bub_stall_prio: got %0h expected 11", M_valE); end
        M_bubble = 1'b0; M_stall = 1'b0;
        set_e(3'd2, 4'h5, 1'b0, 64'h100, 64'h0, 4'hF, 4'h3);
        tick();
        set_nop();
        n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL hlt_req: got %0b expected 0", dmem_req); end
        n_checks++; if (m_stat !== 3'd2) begin n_errors++; $display("FAIL hlt_m_stat: got %0h expected 2", m_stat); end
        tick();
        n_checks++; if (W_stat !== 3'd2) begin n_errors++; $display("FAIL hlt_w_stat: got %0h expected 2", W_stat); end
    endtask

    task automatic test_stalls();
        set_e(3'd1, 4'h6, 1'b1, 64'h77, 64'h0, 4'h5, 4'hF);
        tick();
        set_e(3'd1, 4'h1, 1'b0, 64'h99, 64'h0, 4'h6, 4'hF);
        M_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (M_valE !== 64'h77) begin n_errors++; $display("FAIL mstall_vale_%0d: got %0h expected 77", i, M_valE); end
            n_checks++; if (M_dstE !== 4'h5) begin n_errors++; $display("FAIL mstall_dste_%0d: got %0h expected 5", i, M_dstE); end
        end
        M_stall = 1'b0;
        tick();
        n_checks++; if (M_valE !== 64'h99) begin n_errors++; $display("FAIL mstall_release: got %0h expected 99", M_valE); end
        set_e(3'd1, 4'h5, 1'b0, 64'h200, 64'h0, 4'hF, 4'h7);
        tick();
        set_nop();
        dmem_ack = 1'b1; dmem_rdata = 64'hBEEF;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 64'h0;
        W_stall = 1'b1; M_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (W_stat !== 3'd0) begin n_errors++; $display("FAIL wstall_w_stat_%0d: got %0h expected 0", i, W_stat); end
            n_checks++; if (W_valM !== 64'h0) begin n_errors++; $display("FAIL wstall_w_valm_%0d: got %0h expected 0", i, W_valM); end
            n_checks++; if (m_valM !== 64'hBEEF) begin n_errors++; $display("FAIL wstall_m_valm_%0d: got %0h expected beef", i, m_valM); end
            n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL wstall_req_%0d: got %0b expected 0", i, dmem_req); end
        end
        W_stall = 1'b0; M_stall = 1'b0;
        tick();
        n_checks++; if (W_valM !== 64'hBEEF) begin n_errors++; $display("FAIL wstall_w_load: got %0h expected beef", W_valM); end
        n_checks++; if (W_dstM !== 4'h7) begin n_errors++; $display("FAIL wstall_w_dstm: got %0h expected 7", W_dstM); end
        n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL wstall_no_reissue: got %0b expected 0", dmem_req); end
    endtask

    task automatic test_reset_mid_access();
        set_e(3'd1, 4'h5, 1'b0, 64'h300, 64'h0, 4'hF, 4'h1);
        tick();
        set_nop();
        tick();
        n_checks++; if (dmem_req !== 1'b1) begin n_errors++; $display("FAIL rst_mid_req_before: got %0b expected 1", dmem_req); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL rst_mid_req: got %0b expected 0", dmem_req); end
        n_checks++; if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy: got %0b expected 0", mem_busy); end
        reset = 1'b1;
        tick();
        n_checks++; if (W_stat !== 3'd0) begin n_errors++; $display("FAIL rst_mid_w_stat: got %0h expected 0", W_stat); end
        n_checks++; if (mem_busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_idle: got %0b expected 0", mem_busy); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_mrmovq_latency();
        test_pushq_single_cycle();
        test_addr_limit();
        test_timeout();
        test_cmov();
        test_bubble_and_nonaok();
        test_stalls();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
